// File: rtl/alu_pkg.sv
// alu_pkg: ALUCtrl code set shared by the ALU, the arbiter and its response slots.
package alu_pkg;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_AND  = 4'b0000;
  localparam alu_op_t ALU_OR   = 4'b0001;
  localparam alu_op_t ALU_ADD  = 4'b0010;
  localparam alu_op_t ALU_SLL  = 4'b0011;
  localparam alu_op_t ALU_SRL  = 4'b0100;
  localparam alu_op_t ALU_SUB  = 4'b0110;
  localparam alu_op_t ALU_SLT  = 4'b0111;
  localparam alu_op_t ALU_ADDU = 4'b1000;
  localparam alu_op_t ALU_SUBU = 4'b1001;
  localparam alu_op_t ALU_XOR  = 4'b1010;
  localparam alu_op_t ALU_SLTU = 4'b1011;
  localparam alu_op_t ALU_NOR  = 4'b1100;
  localparam alu_op_t ALU_SRA  = 4'b1101;
  localparam alu_op_t ALU_LUI  = 4'b1110;
  function automatic logic is_legal_op(input alu_op_t op);
    return !(op == 4'b0101 || op == 4'b1111);
  endfunction
endpackage

// File: rtl/alu_rsp_slot.sv
// alu_rsp_slot: one-entry response buffer; a capture on the same edge as a drain
// replaces the entry and keeps valid high.
module alu_rsp_slot
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              grant,
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] data,
  input  logic              zero,
  input  logic [TAG_W-1:0]  tag,
  input  logic              rsp_ready,
  output logic              free,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_illegal,
  output logic [TAG_W-1:0]  rsp_tag
);
  assign free = !rsp_valid || rsp_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_tag     <= '0;
    end else if (grant) begin
      rsp_valid   <= 1'b1;
      rsp_data    <= data;
      rsp_zero    <= zero;
      rsp_illegal <= !is_legal_op(op);
      rsp_tag     <= tag;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between EX (0) and
// the address/branch unit (1). Optional requester lock under macro ALU_SHARE_LOCK_EN.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              CLK,
  input  logic              Resetb,
`ifdef ALU_SHARE_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif
  input  logic              req0_valid,
  output logic              req0_ready,
  input  alu_op_t           req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_zero,
  output logic              rsp0_illegal,
  output logic [TAG_W-1:0]  rsp0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  alu_op_t           req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_zero,
  output logic              rsp1_illegal,
  output logic [TAG_W-1:0]  rsp1_tag,
  output logic [DATA_W-1:0] alu_busa,
  output logic [DATA_W-1:0] alu_busb,
  output alu_op_t           alu_ctrl,
  input  logic [DATA_W-1:0] alu_busw,
  input  logic              alu_zero
);
  logic free0, free1, el0, el1, g0, g1, rr_ptr, block0, block1;
`ifdef ALU_SHARE_LOCK_EN
  logic lock_q, lock_sel;
  // While locked, rr_ptr names the owner and the other side is masked off.
  assign block0   = lock_q && rr_ptr;
  assign block1   = lock_q && !rr_ptr;
  assign lock_sel = g0 ? req0_lock : req1_lock;
  always_ff @(posedge CLK or negedge Resetb)
    if (!Resetb) begin
      rr_ptr <= 1'b0;
      lock_q <= 1'b0;
    end else if (g0 || g1) begin
      rr_ptr <= lock_sel ? g1 : g0;
      lock_q <= lock_sel;
    end
`else
  assign block0 = 1'b0;
  assign block1 = 1'b0;
  always_ff @(posedge CLK or negedge Resetb)
    if (!Resetb) rr_ptr <= 1'b0;
    else if (g0 || g1) rr_ptr <= g0;
`endif
  assign el0 = Resetb && req0_valid && free0 && !block0;
  assign el1 = Resetb && req1_valid && free1 && !block1;
  assign g0  = el0 && (!el1 || !rr_ptr);
  assign g1  = el1 && (!el0 || rr_ptr);
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign alu_ctrl = g0 ? req0_op : g1 ? req1_op : ALU_AND;
  assign alu_busa = g0 ? req0_a : g1 ? req1_a : '0;
  assign alu_busb = g0 ? req0_b : g1 ? req1_b : '0;
  alu_rsp_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_slot0 (
    .clk(CLK), .rst_n(Resetb), .grant(g0), .op(alu_ctrl), .data(alu_busw),
    .zero(alu_zero), .tag(req0_tag), .rsp_ready(rsp0_ready), .free(free0),
    .rsp_valid(rsp0_valid), .rsp_data(rsp0_data), .rsp_zero(rsp0_zero),
    .rsp_illegal(rsp0_illegal), .rsp_tag(rsp0_tag)
  );
  alu_rsp_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_slot1 (
    .clk(CLK), .rst_n(Resetb), .grant(g1), .op(alu_ctrl), .data(alu_busw),
    .zero(alu_zero), .tag(req1_tag), .rsp_ready(rsp1_ready), .free(free1),
    .rsp_valid(rsp1_valid), .rsp_data(rsp1_data), .rsp_zero(rsp1_zero),
    .rsp_illegal(rsp1_illegal), .rsp_tag(rsp1_tag)
  );
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: random + directed stimulus, reference round-robin model and
// per-requester response scoreboards.
module tb_alu_share_arbiter;
  import alu_pkg::*;
  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        illegal;
    logic [3:0]  tag;
  } rsp_t;
  logic CLK = 1'b0;
  logic Resetb = 1'b0;
  logic v[2], rr[2], rdy[2], rv[2], rz[2], ril[2];
  alu_op_t op[2];
  logic [31:0] a[2], b[2], rd[2];
  logic [3:0] tg[2], rt[2];
  logic [31:0] busa, busb, busw;
  alu_op_t ctrl;
  logic zero;
  rsp_t q[2][$];
  int checks = 0;
  int errors = 0;
  int rr_m = 0;
  bit active = 0;

  always #5 CLK = ~CLK;

  alu_share_arbiter #(.DATA_W(32), .TAG_W(4)) dut (
    .CLK(CLK), .Resetb(Resetb),
`ifdef ALU_SHARE_LOCK_EN
    .req0_lock(1'b0), .req1_lock(1'b0),
`endif
    .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_op(op[0]), .req0_a(a[0]),
    .req0_b(b[0]), .req0_tag(tg[0]), .rsp0_valid(rv[0]), .rsp0_ready(rr[0]),
    .rsp0_data(rd[0]), .rsp0_zero(rz[0]), .rsp0_illegal(ril[0]), .rsp0_tag(rt[0]),
    .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_op(op[1]), .req1_a(a[1]),
    .req1_b(b[1]), .req1_tag(tg[1]), .rsp1_valid(rv[1]), .rsp1_ready(rr[1]),
    .rsp1_data(rd[1]), .rsp1_zero(rz[1]), .rsp1_illegal(ril[1]), .rsp1_tag(rt[1]),
    .alu_busa(busa), .alu_busb(busb), .alu_ctrl(ctrl), .alu_busw(busw), .alu_zero(zero)
  );

  function automatic logic [31:0] alu_f(input alu_op_t o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      ALU_AND:  return x & y;
      ALU_OR:   return x | y;
      ALU_ADD, ALU_ADDU: return x + y;
      ALU_SUB, ALU_SUBU: return x - y;
      ALU_SLL:  return x << y[4:0];
      ALU_SRL:  return x >> y[4:0];
      ALU_SRA:  return 32'($signed(x) >>> y[4:0]);
      ALU_SLT:  return {31'b0, $signed(x) < $signed(y)};
      ALU_SLTU: return {31'b0, x < y};
      ALU_XOR:  return x ^ y;
      ALU_NOR:  return ~(x | y);
      ALU_LUI:  return {y[15:0], 16'b0};
      default:  return 32'b0;
    endcase
  endfunction

  // Behavioural ALU sitting on the shared buses.
  assign busw = alu_f(ctrl, busa, busb);
  assign zero = (busw == 32'b0);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented response that is being consumed.
  always @(negedge CLK) begin : mon
    rsp_t e;
    if (Resetb && active)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rsp%0d_valid", i), 32'(rv[i]), 32'(q[i].size() != 0));
        if (rv[i] && rr[i] && q[i].size() != 0) begin
          e = q[i].pop_front();
          chk($sformatf("rsp%0d_data", i), rd[i], e.data);
          chk($sformatf("rsp%0d_zero", i), 32'(rz[i]), 32'(e.zero));
          chk($sformatf("rsp%0d_illegal", i), 32'(ril[i]), 32'(e.illegal));
          chk($sformatf("rsp%0d_tag", i), 32'(rt[i]), 32'(e.tag));
        end
      end
  end

  // Reference arbiter: a requester may go if it has a request and no response
  // left unconsumed; ties go to the side named by the round-robin pointer.
  always @(negedge CLK) begin : arb
    bit el[2];
    int w;
    rsp_t e;
    #1;
    if (Resetb && active) begin
      for (int i = 0; i < 2; i++) el[i] = v[i] && (q[i].size() == 0 || rr[i]);
      w = (el[0] && el[1]) ? rr_m : el[0] ? 0 : el[1] ? 1 : -1;
      for (int i = 0; i < 2; i++)
        chk($sformatf("req%0d_ready", i), 32'(rdy[i]), 32'(w == i));
      if (w >= 0) begin
        e.data = alu_f(op[w], a[w], b[w]);
        e.zero = (e.data == 32'b0);
        e.illegal = (op[w] == 4'b0101 || op[w] == 4'b1111);
        e.tag = tg[w];
        q[w].push_back(e);
        rr_m = 1 - w;
      end
    end
  end

  task automatic set(input int i, input bit vv, input alu_op_t o, input logic [31:0] x,
                     input logic [31:0] y, input logic [3:0] t, input bit r);
    v[i] = vv; op[i] = o; a[i] = x; b[i] = y; tg[i] = t; rr[i] = r;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst rsp%0d_valid", i), 32'(rv[i]), 32'd0);
      chk($sformatf("rst req%0d_ready", i), 32'(rdy[i]), 32'd0);
      chk($sformatf("rst rsp%0d_data", i), rd[i], 32'd0);
      chk($sformatf("rst rsp%0d_flags", i), {30'b0, rz[i], ril[i]}, 32'd0);
      chk($sformatf("rst rsp%0d_tag", i), 32'(rt[i]), 32'd0);
    end
  endtask

  // Asynchronous reset between edges, with both requesters asking.
  task automatic do_reset();
    v[0] = 1'b1; v[1] = 1'b1;
    @(negedge CLK);
    #3 Resetb = 1'b0;
    #1 check_reset_outputs();
    q[0].delete(); q[1].delete(); rr_m = 0;
    v[0] = 1'b0; v[1] = 1'b0;
    @(posedge CLK);
    #1 Resetb = 1'b1;
  endtask

  function automatic logic [31:0] rnd_val();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
  endfunction

  initial begin
    set(0, 0, ALU_AND, 0, 0, 0, 1);
    set(1, 0, ALU_AND, 0, 0, 0, 1);
    v[0] = 1'b1; v[1] = 1'b1;
    #1 check_reset_outputs();
    v[0] = 1'b0; v[1] = 1'b0;
    @(posedge CLK);
    #1 Resetb = 1'b1;
    active = 1;
    set(0, 1, ALU_ADD, 5, 7, 3, 1);
    step(1);
    chk("single rsp0_data", rd[0], 32'd12);
    chk("single rsp0_tag", 32'(rt[0]), 32'd3);
    v[0] = 1'b0;
    step(1);
    do_reset();
    set(0, 1, ALU_SUB, 9, 9, 1, 1);
    set(1, 1, ALU_OR, 1, 2, 2, 1);
    step(1);
    chk("contend rsp0_zero", 32'(rz[0]), 32'd1);
    step(1);
    chk("contend rsp1_data", rd[1], 32'd3);
    step(2);
    set(1, 1, ALU_XOR, 32'hF0, 32'h0F, 4, 0);
    set(0, 1, ALU_ADD, 1, 2, 6, 1);
    step(5);
    rr[1] = 1'b1;
    step(2);
    v[0] = 1'b0; v[1] = 1'b0;
    step(1);
    set(0, 1, 4'b1111, 8, 8, 5, 1);
    step(1);
    chk("illegal data", rd[0], 32'd0);
    chk("illegal flags", {30'b0, rz[0], ril[0]}, 32'd3);
    set(0, 1, ALU_ADD, 1, 1, 7, 0);
    step(1);
    v[0] = 1'b0;
    chk("pre-reset rsp0_valid", 32'(rv[0]), 32'd1);
    do_reset();
    rr[0] = 1'b1; rr[1] = 1'b1;
    set(0, 1, ALU_SLT, 32'hFFFF_FFFF, 1, 8, 1);
    set(1, 1, ALU_SLTU, 32'hFFFF_FFFF, 1, 9, 1);
    step(3);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++)
        set(i, 1'($urandom_range(0, 1)), alu_op_t'($urandom_range(0, 15)), rnd_val(),
            rnd_val(), 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      step(1);
    end
    v[0] = 1'b0; v[1] = 1'b0; rr[0] = 1'b1; rr[1] = 1'b1;
    step(3);
    chk("drain q0", 32'(q[0].size()), 32'd0);
    chk("drain q1", 32'(q[1].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
